stack_ctrl_fsm: RTL and testbench

Multicycle control unit for the 8-bit stack-machine datapath (5-bit PC/address, 3-bit opcode in IR[7:5], hardware stack, A/B/Z/AluOut/MDR registers). It sequences fetch, decode and execute for all eight opcodes by driving every datapath control input from a Moore state machine. It also provides a start/stop run handshake and a retired-instruction counter for the testbench and top level.

---
 rtl/stack_ctrl_fsm_if.sv | 39 +++
 rtl/stack_ctrl_fsm.sv | 141 ++++++++++++++
 tb/tb_stack_ctrl_fsm.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stack_ctrl_fsm_if.sv
// Control bus between the stack-machine controller and its datapath/top level.
// The controller takes the master side; the datapath (or bench) takes the slave side.
interface stack_ctrl_fsm_if;
    logic       start;
    logic       stop;
    logic [2:0] OPC;
    logic       busy;
    logic [7:0] instCount;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       SrcA;
    logic       SrcB;
    logic       LdA;
    logic       LdB;
    logic       PCWrite;
    logic       PCSrc;
    logic       tos;
    logic       Push;
    logic       Pop;
    logic       PCWriteCond;
    logic       MtoS;
    logic [1:0] AluOP;

    modport master (
        input  start, stop, OPC,
        output busy, instCount,
        output IorD, memRead, memWrite, IRWrite, SrcA, SrcB, LdA, LdB,
        output PCWrite, PCSrc, tos, Push, Pop, PCWriteCond, MtoS, AluOP
    );

    modport slave (
        output start, stop, OPC,
        input  busy, instCount,
        input  IorD, memRead, memWrite, IRWrite, SrcA, SrcB, LdA, LdB,
        input  PCWrite, PCSrc, tos, Push, Pop, PCWriteCond, MtoS, AluOP
    );
endinterface

// File: rtl/stack_ctrl_fsm.sv
// Moore multicycle controller for the 8-bit stack-machine datapath: fetch, decode
// and execute sequencing, start/stop run handshake and a retired-instruction counter.
module stack_ctrl_fsm (
    input  logic            clk,
    input  logic            rst,
    stack_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_IF, S_ID, S_POPA, S_POPB, S_EXE, S_WB,
        S_MRD, S_PWB, S_SPOP, S_MWR, S_JMP, S_JZT, S_JZB
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       retire;
    logic [7:0] inst_count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            inst_count <= 8'd0;
        end else begin
            state <= state_nxt;
            if (retire)
                inst_count <= inst_count + 8'd1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt       = state;
        retire          = 1'b0;
        bus.IorD        = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.SrcA        = 1'b0;
        bus.SrcB        = 1'b0;
        bus.LdA         = 1'b0;
        bus.LdB         = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.tos         = 1'b0;
        bus.Push        = 1'b0;
        bus.Pop         = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.MtoS        = 1'b0;
        bus.AluOP       = 2'b00;

        case (state)
            S_IDLE: begin
                if (bus.start)
                    state_nxt = S_IF;
            end
            S_IF: begin
                // PC + 1 via the ALU while the instruction lands in IR
                bus.memRead = 1'b1;
                bus.IRWrite = 1'b1;
                bus.SrcA    = 1'b1;
                bus.SrcB    = 1'b1;
                bus.PCWrite = 1'b1;
                state_nxt   = S_ID;
            end
            S_ID: begin
                case (bus.OPC)
                    3'b100:  state_nxt = S_MRD;
                    3'b101:  state_nxt = S_SPOP;
                    3'b110:  state_nxt = S_JMP;
                    3'b111:  state_nxt = S_JZT;
                    default: state_nxt = S_POPA;
                endcase
            end
            S_POPA: begin
                bus.Pop   = 1'b1;
                bus.LdA   = 1'b1;
                // NOT is unary, so it needs only one operand off the stack
                state_nxt = (bus.OPC == 3'b011) ? S_EXE : S_POPB;
            end
            S_POPB: begin
                bus.Pop   = 1'b1;
                bus.LdB   = 1'b1;
                state_nxt = S_EXE;
            end
            S_EXE: begin
                bus.AluOP = bus.OPC[1:0];
                state_nxt = S_WB;
            end
            S_WB: begin
                bus.Push = 1'b1;
                retire   = 1'b1;
            end
            S_MRD: begin
                bus.IorD    = 1'b1;
                bus.memRead = 1'b1;
                state_nxt   = S_PWB;
            end
            S_PWB: begin
                bus.Push = 1'b1;
                bus.MtoS = 1'b1;
                retire   = 1'b1;
            end
            S_SPOP: begin
                bus.Pop   = 1'b1;
                bus.LdA   = 1'b1;
                state_nxt = S_MWR;
            end
            S_MWR: begin
                bus.IorD     = 1'b1;
                bus.memWrite = 1'b1;
                retire       = 1'b1;
            end
            S_JMP: begin
                bus.PCSrc   = 1'b1;
                bus.PCWrite = 1'b1;
                retire      = 1'b1;
            end
            S_JZT: begin
                // Expose top of stack without popping so Z captures it this edge
                bus.tos   = 1'b1;
                state_nxt = S_JZB;
            end
            S_JZB: begin
                bus.PCSrc       = 1'b1;
                bus.PCWriteCond = 1'b1;
                retire          = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (retire)
            state_nxt = bus.stop ? S_IDLE : S_IF;
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.instCount = inst_count;

endmodule

// File: tb/tb_stack_ctrl_fsm.sv
// Directed bench for stack_ctrl_fsm: a per-cycle vector table covering every
// opcode's control sequence, plus hand sequences for reset, wrap and single-step.
module tb_stack_ctrl_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_ctrl_fsm_if bus ();

    stack_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Control word: {IorD,memRead,memWrite,IRWrite,SrcA,SrcB,LdA,LdB,PCWrite,
    //                PCSrc,tos,Push,Pop,PCWriteCond,MtoS,AluOP[1:0]}
    localparam logic [16:0] C_IORD  = 17'h10000;
    localparam logic [16:0] C_MRD   = 17'h08000;
    localparam logic [16:0] C_MWR   = 17'h04000;
    localparam logic [16:0] C_IRW   = 17'h02000;
    localparam logic [16:0] C_SRCA  = 17'h01000;
    localparam logic [16:0] C_SRCB  = 17'h00800;
    localparam logic [16:0] C_LDA   = 17'h00400;
    localparam logic [16:0] C_LDB   = 17'h00200;
    localparam logic [16:0] C_PCW   = 17'h00100;
    localparam logic [16:0] C_PCSRC = 17'h00080;
    localparam logic [16:0] C_TOS   = 17'h00040;
    localparam logic [16:0] C_PUSH  = 17'h00020;
    localparam logic [16:0] C_POP   = 17'h00010;
    localparam logic [16:0] C_PCWC  = 17'h00008;
    localparam logic [16:0] C_MTOS  = 17'h00004;
    localparam logic [16:0] C_FETCH = C_MRD | C_IRW | C_SRCA | C_SRCB | C_PCW;

    typedef struct {
        logic        start;
        logic        stop;
        logic [2:0]  opc;
        logic [16:0] ctrl;
        logic        busy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [16:0] get_ctrl();
        return {bus.IorD, bus.memRead, bus.memWrite, bus.IRWrite, bus.SrcA, bus.SrcB,
                bus.LdA, bus.LdB, bus.PCWrite, bus.PCSrc, bus.tos, bus.Push, bus.Pop,
                bus.PCWriteCond, bus.MtoS, bus.AluOP};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic st, input logic sp, input logic [2:0] opc,
                           input logic [16:0] ctrl, input logic busy, input logic [7:0] cnt);
        vec_t v;
        v.start = st; v.stop = sp; v.opc = opc; v.ctrl = ctrl; v.busy = busy; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.OPC   = 3'b000;

        // Reset held with random inputs
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.start = 1'($urandom_range(0, 1));
            bus.stop  = 1'($urandom_range(0, 1));
            bus.OPC   = 3'($urandom_range(0, 7));
            #1;
            check($sformatf("rst_ctrl%0d", i), 32'(get_ctrl()), 32'd0);
            check($sformatf("rst_busy%0d", i), 32'(bus.busy), 32'd0);
            check($sformatf("rst_cnt%0d", i), 32'(bus.instCount), 32'd0);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.OPC   = 3'b000;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle_busy%0d", i), 32'(bus.busy), 32'd0);
        end

        // Per-cycle table: {start, stop, opc, controls, busy, instCount}
        add_vec(0, 0, 3'b000, 17'd0,              0, 8'd0);  // IDLE
        add_vec(1, 0, 3'b000, 17'd0,              0, 8'd0);  // IDLE, start sampled
        add_vec(0, 0, 3'b000, C_FETCH,            1, 8'd0);  // ADD: IF
        add_vec(0, 0, 3'b000, 17'd0,              1, 8'd0);  // ID
        add_vec(0, 0, 3'b000, C_POP | C_LDA,      1, 8'd0);  // POPA
        add_vec(0, 0, 3'b000, C_POP | C_LDB,      1, 8'd0);  // POPB
        add_vec(0, 0, 3'b000, 17'd0,              1, 8'd0);  // EXE add
        add_vec(0, 0, 3'b000, C_PUSH,             1, 8'd0);  // WB
        add_vec(1, 0, 3'b011, C_FETCH,            1, 8'd1);  // NOT: IF, start ignored
        add_vec(1, 0, 3'b011, 17'd0,              1, 8'd1);  // ID
        add_vec(0, 0, 3'b011, C_POP | C_LDA,      1, 8'd1);  // POPA
        add_vec(0, 0, 3'b011, 17'd3,              1, 8'd1);  // EXE not
        add_vec(0, 0, 3'b011, C_PUSH,             1, 8'd1);  // WB
        add_vec(0, 0, 3'b001, C_FETCH,            1, 8'd2);  // SUB: IF
        add_vec(0, 0, 3'b001, 17'd0,              1, 8'd2);
        add_vec(0, 0, 3'b001, C_POP | C_LDA,      1, 8'd2);
        add_vec(0, 0, 3'b001, C_POP | C_LDB,      1, 8'd2);
        add_vec(0, 0, 3'b001, 17'd1,              1, 8'd2);  // EXE sub
        add_vec(0, 0, 3'b001, C_PUSH,             1, 8'd2);
        add_vec(0, 0, 3'b010, C_FETCH,            1, 8'd3);  // AND: IF
        add_vec(0, 0, 3'b010, 17'd0,              1, 8'd3);
        add_vec(0, 0, 3'b010, C_POP | C_LDA,      1, 8'd3);
        add_vec(0, 0, 3'b010, C_POP | C_LDB,      1, 8'd3);
        add_vec(0, 0, 3'b010, 17'd2,              1, 8'd3);  // EXE and
        add_vec(0, 0, 3'b010, C_PUSH,             1, 8'd3);
        add_vec(0, 0, 3'b100, C_FETCH,            1, 8'd4);  // PUSH: IF
        add_vec(0, 1, 3'b100, 17'd0,              1, 8'd4);  // ID, stop not sampled
        add_vec(0, 1, 3'b100, C_IORD | C_MRD,     1, 8'd4);  // MRD
        add_vec(0, 0, 3'b100, C_PUSH | C_MTOS,    1, 8'd4);  // PWB
        add_vec(0, 0, 3'b101, C_FETCH,            1, 8'd5);  // POP: IF
        add_vec(0, 0, 3'b101, 17'd0,              1, 8'd5);
        add_vec(0, 0, 3'b101, C_POP | C_LDA,      1, 8'd5);  // SPOP
        add_vec(0, 0, 3'b101, C_IORD | C_MWR,     1, 8'd5);  // MWR
        add_vec(0, 0, 3'b111, C_FETCH,            1, 8'd6);  // JZ: IF
        add_vec(0, 0, 3'b111, 17'd0,              1, 8'd6);
        add_vec(0, 0, 3'b111, C_TOS,              1, 8'd6);  // JZT
        add_vec(0, 0, 3'b111, C_PCSRC | C_PCWC,   1, 8'd6);  // JZB
        add_vec(0, 0, 3'b110, C_FETCH,            1, 8'd7);  // JMP: IF
        add_vec(0, 0, 3'b110, 17'd0,              1, 8'd7);
        add_vec(0, 1, 3'b110, C_PCSRC | C_PCW,    1, 8'd7);  // JMP, stop at retire
        add_vec(0, 1, 3'b110, 17'd0,              0, 8'd8);  // IDLE
        add_vec(0, 0, 3'b000, 17'd0,              0, 8'd8);  // IDLE holds

        foreach (vecs[i]) begin
            bus.start = vecs[i].start;
            bus.stop  = vecs[i].stop;
            bus.OPC   = vecs[i].opc;
            #1;
            check($sformatf("vec%0d_ctrl", i), 32'(get_ctrl()), 32'(vecs[i].ctrl));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].busy));
            check($sformatf("vec%0d_cnt", i), 32'(bus.instCount), 32'(vecs[i].cnt));
            tick();
        end

        // 256 JMPs from a clean count: counter wraps and stop ends the run
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        bus.OPC   = 3'b110;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.instCount == 8'd255)
                break;
            tick();
        end
        check("wrap_reach255", 32'(bus.instCount), 32'd255);
        check("wrap_last_if", 32'(get_ctrl()), 32'(C_FETCH));
        bus.stop = 1'b1;
        tick();
        tick();
        check("wrap_jmp_busy", 32'(bus.busy), 32'd1);
        tick();
        check("wrap_busy_fall", 32'(bus.busy), 32'd0);
        check("wrap_cnt0", 32'(bus.instCount), 32'd0);

        // start and stop together: exactly one instruction
        bus.OPC   = 3'b000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("step_busy%0d", k), 32'(bus.busy), 32'd1);
            tick();
        end
        check("step_idle", 32'(bus.busy), 32'd0);
        check("step_cnt", 32'(bus.instCount), 32'd1);
        tick();
        tick();
        check("step_stay_idle", 32'(bus.busy), 32'd0);
        check("step_stay_cnt", 32'(bus.instCount), 32'd1);

        // Reset asserted during EXE aborts at once
        bus.stop  = 1'b0;
        bus.OPC   = 3'b001;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("exe_before_rst", 32'(get_ctrl()), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_exe_ctrl", 32'(get_ctrl()), 32'd0);
        check("rst_exe_busy", 32'(bus.busy), 32'd0);
        check("rst_exe_cnt", 32'(bus.instCount), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        check("post_rst_ctrl", 32'(get_ctrl()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
